// File: rtl/rvfi_retire_queue.sv
// RVFI retirement queue: compacts sparse retire lanes into a circular FIFO and
// drains up to NRET_OUT records per cycle onto registered RVFI lanes, each
// stamped with a monotonic 64-bit order number.
module rvfi_retire_queue #(
    parameter int NRET_IN  = 2,
    parameter int NRET_OUT = 1,
    parameter int REC_W    = 334,
    parameter int DEPTH    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NRET_IN-1:0]        in_valid,
    input  logic [NRET_IN*REC_W-1:0]  in_rec,
    output logic                      in_ready,
    output logic [NRET_OUT-1:0]       out_valid,
    output logic [NRET_OUT*64-1:0]    out_order,
    output logic [NRET_OUT*REC_W-1:0] out_rec,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [63:0]      order_cnt;
    logic [PTR_W-1:0] wr_off [NRET_IN];
    logic [LVL_W-1:0] push_cnt;
    logic [LVL_W-1:0] push_k;
    logic [LVL_W-1:0] pop_cnt;
    logic             push_en;

    // Readiness comes only from the registered level so it never depends on in_valid.
    assign in_ready = (level <= LVL_W'(DEPTH - NRET_IN));
    assign push_en  = in_ready && (in_valid != '0);
    assign push_k   = push_en ? push_cnt : '0;

    // Compact valid lanes: each valid lane lands at wr_ptr plus the count of valid lanes below it.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < NRET_IN; i++) begin
            wr_off[i] = push_cnt[PTR_W-1:0];
            if (in_valid[i]) begin
                push_cnt = push_cnt + LVL_W'(1);
            end
        end
    end

    // Pop as many of the oldest entries as there are output lanes, bounded by occupancy.
    always_comb begin
        pop_cnt = level;
        if (int'(level) >= NRET_OUT) begin
            pop_cnt = LVL_W'(NRET_OUT);
        end
    end

    // Record storage; contents are don't-care until written, so no reset here.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET_IN; i++) begin
            if (push_en && in_valid[i]) begin
                mem[wr_ptr + wr_off[i]] <= in_rec[i*REC_W +: REC_W];
            end
        end
    end

    // Pointers, occupancy, order counter, sticky overflow and the registered output lanes.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            order_cnt <= '0;
            overflow  <= 1'b0;
            out_valid <= '0;
            out_order <= '0;
            out_rec   <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + push_cnt[PTR_W-1:0];
            end
            rd_ptr    <= rd_ptr + pop_cnt[PTR_W-1:0];
            level     <= level + push_k - pop_cnt;
            order_cnt <= order_cnt + 64'(pop_cnt);
            if ((in_valid != '0) && !in_ready) begin
                overflow <= 1'b1;
            end
            for (int j = 0; j < NRET_OUT; j++) begin
                if (j < int'(pop_cnt)) begin
                    out_valid[j]                 <= 1'b1;
                    out_order[j*64 +: 64]        <= order_cnt + 64'(j);
                    out_rec[j*REC_W +: REC_W]    <= mem[rd_ptr + PTR_W'(j)];
                end else begin
                    out_valid[j]                 <= 1'b0;
                    out_order[j*64 +: 64]        <= '0;
                    out_rec[j*REC_W +: REC_W]    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_queue.sv
// Testbench for rvfi_retire_queue: two instances (1 and 2 output lanes) share
// the same input stream and are checked against a queue-based reference model.
module tb_rvfi_retire_queue;

    localparam int NIN   = 2;
    localparam int DEPTH = 8;
    localparam int W     = 334;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic [NIN-1:0]   in_valid;
    logic [NIN*W-1:0] in_rec;

    logic             rdy1, ovf1;
    logic [0:0]       val1;
    logic [63:0]      ord1;
    logic [W-1:0]     rec1;
    logic [LW-1:0]    lvl1;

    logic             rdy2, ovf2;
    logic [1:0]       val2;
    logic [127:0]     ord2;
    logic [2*W-1:0]   rec2;
    logic [LW-1:0]    lvl2;

    // Reference model state
    logic [W-1:0]     q1[$];
    logic [W-1:0]     q2[$];
    logic [63:0]      cnt1, cnt2;
    logic             e_ovf1, e_ovf2, e_rdy1, e_rdy2;
    logic [0:0]       e_val1;
    logic [63:0]      e_ord1;
    logic [W-1:0]     e_rec1;
    logic [1:0]       e_val2;
    logic [127:0]     e_ord2;
    logic [2*W-1:0]   e_rec2;
    logic [LW-1:0]    e_lvl1, e_lvl2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    rvfi_retire_queue #(.NRET_IN(NIN), .NRET_OUT(1), .REC_W(W), .DEPTH(DEPTH)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_rec(in_rec),
        .in_ready(rdy1), .out_valid(val1), .out_order(ord1), .out_rec(rec1),
        .overflow(ovf1), .level(lvl1)
    );

    rvfi_retire_queue #(.NRET_IN(NIN), .NRET_OUT(2), .REC_W(W), .DEPTH(DEPTH)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_rec(in_rec),
        .in_ready(rdy2), .out_valid(val2), .out_order(ord2), .out_rec(rec2),
        .overflow(ovf2), .level(lvl2)
    );

    function automatic logic [W-1:0] rand_rec();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) begin
            t[i*32 +: 32] = $urandom;
        end
        return t[W-1:0];
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
    task automatic cycle(input logic rst, input logic [NIN-1:0] v, input logic [NIN*W-1:0] r);
        logic ready1_pre, ready2_pre;
        reset      = rst;
        in_valid   = v;
        in_rec     = r;
        ready1_pre = (q1.size() <= DEPTH - NIN);
        ready2_pre = (q2.size() <= DEPTH - NIN);
        @(posedge clock);
        if (rst) begin
            q1.delete();
            q2.delete();
            cnt1 = '0;  cnt2 = '0;
            e_ovf1 = 1'b0; e_ovf2 = 1'b0;
            e_val1 = '0; e_ord1 = '0; e_rec1 = '0;
            e_val2 = '0; e_ord2 = '0; e_rec2 = '0;
        end else begin
            e_val1 = '0; e_ord1 = '0; e_rec1 = '0;
            if (q1.size() > 0) begin
                e_val1 = 1'b1;
                e_ord1 = cnt1;
                e_rec1 = q1.pop_front();
                cnt1   = cnt1 + 64'd1;
            end
            e_val2 = '0; e_ord2 = '0; e_rec2 = '0;
            for (int j = 0; j < 2; j++) begin
                if (q2.size() > 0) begin
                    e_val2[j]          = 1'b1;
                    e_ord2[j*64 +: 64] = cnt2;
                    e_rec2[j*W +: W]   = q2.pop_front();
                    cnt2               = cnt2 + 64'd1;
                end
            end
            for (int i = 0; i < NIN; i++) begin
                if (v[i]) begin
                    if (ready1_pre) q1.push_back(r[i*W +: W]);
                    if (ready2_pre) q2.push_back(r[i*W +: W]);
                end
            end
            if (v != '0 && !ready1_pre) e_ovf1 = 1'b1;
            if (v != '0 && !ready2_pre) e_ovf2 = 1'b1;
        end
        e_lvl1 = LW'(q1.size());
        e_lvl2 = LW'(q2.size());
        e_rdy1 = (q1.size() <= DEPTH - NIN);
        e_rdy2 = (q2.size() <= DEPTH - NIN);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 2'b11, {rand_rec(), rand_rec()});
        cycle(1'b1, 2'b11, {rand_rec(), rand_rec()});
        n_cmp++;
        if ({val1, ord1, rec1} !== {1'b0, 64'd0, {W{1'b0}}}) begin
            n_fail++;
            $display("[TB] FAIL reset_out1: got v=%b ord=%0d, want 0/0", val1, ord1);
        end
        n_cmp++;
        if ({lvl1, ovf1, rdy1} !== {LW'(0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL reset_state1: got lvl=%0d ovf=%b rdy=%b, want 0/0/1", lvl1, ovf1, rdy1);
        end
        n_cmp++;
        if ({val2, ord2, lvl2, ovf2} !== {2'b00, 128'd0, LW'(0), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_dut2: got v=%b ord=%h lvl=%0d ovf=%b, want all zero", val2, ord2, lvl2, ovf2);
        end
    endtask

    task automatic test_sparse();
        logic [W-1:0] a, b, c;
        a = rand_rec(); b = rand_rec(); c = rand_rec();
        cycle(1'b1, 2'b00, '0);
        cycle(1'b0, 2'b10, {a, {W{1'b0}}});
        n_cmp++;
        if (val1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sparse_nobypass: got v=%b, want 0", val1);
        end
        cycle(1'b0, 2'b11, {c, b});
        n_cmp++;
        if ({val1, ord1, rec1} !== {1'b1, 64'd0, a}) begin
            n_fail++;
            $display("[TB] FAIL sparse_A: got v=%b ord=%0d rec=%h, want 1/0/%h", val1, ord1, rec1, a);
        end
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0, 2'b00, '0);
            n_cmp++;
            if ({val1, ord1, rec1} !== {e_val1, e_ord1, e_rec1}) begin
                n_fail++;
                $display("[TB] FAIL sparse_out1: got v=%b ord=%0d rec=%h, want v=%b ord=%0d rec=%h", val1, ord1, rec1, e_val1, e_ord1, e_rec1);
            end
            if (n == 0) begin
                n_cmp++;
                if ({ord1, rec1} !== {64'd1, b}) begin
                    n_fail++;
                    $display("[TB] FAIL sparse_B: got ord=%0d rec=%h, want 1/%h", ord1, rec1, b);
                end
            end
            if (n == 1) begin
                n_cmp++;
                if ({ord1, rec1} !== {64'd2, c}) begin
                    n_fail++;
                    $display("[TB] FAIL sparse_C: got ord=%0d rec=%h, want 2/%h", ord1, rec1, c);
                end
            end
        end
    endtask

    task automatic test_fill();
        cycle(1'b1, 2'b00, '0);
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, 2'b11, {rand_rec(), rand_rec()});
            if (n == 5) begin
                n_cmp++;
                if ({lvl1, rdy1} !== {LW'(7), 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL fill_full: got lvl=%0d rdy=%b, want 7/0", lvl1, rdy1);
                end
            end
            n_cmp++;
            if ({rdy1, ovf1, lvl1} !== {e_rdy1, e_ovf1, e_lvl1}) begin
                n_fail++;
                $display("[TB] FAIL fill_state1: got rdy=%b ovf=%b lvl=%0d, want rdy=%b ovf=%b lvl=%0d", rdy1, ovf1, lvl1, e_rdy1, e_ovf1, e_lvl1);
            end
        end
        n_cmp++;
        if (ovf1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fill_overflow: got ovf=%b, want 1", ovf1);
        end
        for (int n = 0; n < 12; n++) begin
            cycle(1'b0, 2'b00, '0);
            n_cmp++;
            if ({val1, ord1, rec1} !== {e_val1, e_ord1, e_rec1}) begin
                n_fail++;
                $display("[TB] FAIL fill_drain1: got v=%b ord=%0d rec=%h, want v=%b ord=%0d rec=%h", val1, ord1, rec1, e_val1, e_ord1, e_rec1);
            end
        end
        n_cmp++;
        if ({lvl1, ovf1} !== {LW'(0), 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL fill_empty: got lvl=%0d ovf=%b, want 0/1", lvl1, ovf1);
        end
    endtask

    task automatic test_drain2();
        logic [W-1:0] a, b, c;
        a = rand_rec(); b = rand_rec(); c = rand_rec();
        cycle(1'b1, 2'b00, '0);
        cycle(1'b0, 2'b11, {b, a});
        cycle(1'b0, 2'b01, {{W{1'b0}}, c});
        n_cmp++;
        if ({val2, ord2, rec2} !== {2'b11, 64'd1, 64'd0, b, a}) begin
            n_fail++;
            $display("[TB] FAIL drain2_first: got v=%b ord=%h, want v=11 ord=1,0", val2, ord2);
        end
        cycle(1'b0, 2'b00, '0);
        n_cmp++;
        if ({val2, ord2, rec2} !== {2'b01, 64'd0, 64'd2, {W{1'b0}}, c}) begin
            n_fail++;
            $display("[TB] FAIL drain2_second: got v=%b ord=%h, want v=01 ord=0,2", val2, ord2);
        end
        cycle(1'b0, 2'b00, '0);
        n_cmp++;
        if ({val2, lvl2} !== {2'b00, LW'(0)}) begin
            n_fail++;
            $display("[TB] FAIL drain2_empty: got v=%b lvl=%0d, want 00/0", val2, lvl2);
        end
    endtask

    task automatic test_wrap();
        int seen;
        seen = 0;
        cycle(1'b1, 2'b00, '0);
        for (int n = 0; n < 26; n++) begin
            if (n < 20 && (n % 2 == 0)) cycle(1'b0, 2'b11, {rand_rec(), rand_rec()});
            else                        cycle(1'b0, 2'b00, '0);
            n_cmp++;
            if ({val1, ord1, rec1} !== {e_val1, e_ord1, e_rec1}) begin
                n_fail++;
                $display("[TB] FAIL wrap_out1: got v=%b ord=%0d rec=%h, want v=%b ord=%0d rec=%h", val1, ord1, rec1, e_val1, e_ord1, e_rec1);
            end
            if (val1 === 1'b1) begin
                n_cmp++;
                if (ord1 !== 64'(seen)) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_seq: got ord=%0d, want %0d", ord1, seen);
                end
                seen++;
            end
        end
        n_cmp++;
        if (seen !== 20) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: got %0d records, want 20", seen);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] a;
        a = rand_rec();
        cycle(1'b1, 2'b00, '0);
        for (int n = 0; n < 4; n++) cycle(1'b0, 2'b11, {rand_rec(), rand_rec()});
        n_cmp++;
        if (lvl1 !== LW'(5)) begin
            n_fail++;
            $display("[TB] FAIL midop_level: got lvl=%0d, want 5", lvl1);
        end
        cycle(1'b1, 2'b00, '0);
        n_cmp++;
        if ({val1, lvl1, val2, lvl2} !== {1'b0, LW'(0), 2'b00, LW'(0)}) begin
            n_fail++;
            $display("[TB] FAIL midop_flush: got v1=%b lvl1=%0d v2=%b lvl2=%0d, want all 0", val1, lvl1, val2, lvl2);
        end
        cycle(1'b0, 2'b01, {{W{1'b0}}, a});
        cycle(1'b0, 2'b00, '0);
        n_cmp++;
        if ({val1, ord1, rec1} !== {1'b1, 64'd0, a}) begin
            n_fail++;
            $display("[TB] FAIL midop_restart: got v=%b ord=%0d rec=%h, want 1/0/%h", val1, ord1, rec1, a);
        end
    endtask

    task automatic test_random();
        logic rst;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            cycle(rst, NIN'($urandom_range(0, 3)), {rand_rec(), rand_rec()});
            n_cmp++;
            if ({val1, ord1, rec1} !== {e_val1, e_ord1, e_rec1}) begin
                n_fail++;
                $display("[TB] FAIL random_out1: got v=%b ord=%0d rec=%h, want v=%b ord=%0d rec=%h", val1, ord1, rec1, e_val1, e_ord1, e_rec1);
            end
            n_cmp++;
            if ({rdy1, ovf1, lvl1} !== {e_rdy1, e_ovf1, e_lvl1}) begin
                n_fail++;
                $display("[TB] FAIL random_state1: got rdy=%b ovf=%b lvl=%0d, want rdy=%b ovf=%b lvl=%0d", rdy1, ovf1, lvl1, e_rdy1, e_ovf1, e_lvl1);
            end
            n_cmp++;
            if ({val2, ord2} !== {e_val2, e_ord2}) begin
                n_fail++;
                $display("[TB] FAIL random_ord2: got v=%b ord=%h, want v=%b ord=%h", val2, ord2, e_val2, e_ord2);
            end
            n_cmp++;
            if (rec2 !== e_rec2) begin
                n_fail++;
                $display("[TB] FAIL random_rec2: got %h, want %h", rec2, e_rec2);
            end
            n_cmp++;
            if ({rdy2, ovf2, lvl2} !== {e_rdy2, e_ovf2, e_lvl2}) begin
                n_fail++;
                $display("[TB] FAIL random_state2: got rdy=%b ovf=%b lvl=%0d, want rdy=%b ovf=%b lvl=%0d", rdy2, ovf2, lvl2, e_rdy2, e_ovf2, e_lvl2);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_rec   = '0;
        test_reset();
        test_sparse();
        test_fill();
        test_drain2();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
